lsu_stack_seq: RTL and testbench

LSU_STACK_SEQ -- requirements
Module: lsu_stack_seq

---
 rtl/lsu_stack_seq.sv | 147 ++++++++++++++
 tb/tb_lsu_stack_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_stack_seq.sv
`default_nettype none
// ============================================================================
// Module  : lsu_stack_seq
// Brief   : Sequenced load/store unit with hardware stack pointer (LD/ST/PUSH/POP).
//           Optional macro LSU_BOUNDS_CHECK_EN enables effective-address faulting.
// Rev     : 1.0
// ============================================================================
module lsu_stack_seq #(
  parameter logic [7:0] SP_INIT = 8'd32,
  parameter logic [7:0] MEM_TOP = 8'd32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [1:0] op_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [7:0] sp_o,
  output logic       err_o,
  output logic       mem_e_o,
  output logic       mem_we_o,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_di_o,
  input  logic [7:0] mem_do_i
);

  localparam logic [1:0] OP_LD   = 2'b00;
  localparam logic [1:0] OP_ST   = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CAPT  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sp_q, sp_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] di_q, di_d;
  logic       err_q, err_d;
  logic       push_q, push_d;

  logic [7:0] eff_addr;
  logic       is_write;
  logic       fault;

  always_comb begin
    eff_addr = addr_i;
    case (op_i)
      OP_LD, OP_ST: eff_addr = addr_i;
      OP_PUSH:      eff_addr = sp_q;
      OP_POP:       eff_addr = sp_q + 8'd1;
      default:      eff_addr = addr_i;
    endcase
    is_write = (op_i == OP_ST) || (op_i == OP_PUSH);
`ifdef LSU_BOUNDS_CHECK_EN
    fault = (eff_addr > MEM_TOP);
`else
    fault = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    di_d    = di_q;
    err_d   = err_q;
    push_d  = push_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        err_d = 1'b0;
        if (req_i) begin
          if (fault) begin
            // Faulting requests skip the memory entirely and report in DONE.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d = eff_addr;
            push_d = (op_i == OP_PUSH);
            if (is_write) begin
              di_d    = wdata_i;
              state_d = S_WRITE;
            end else begin
              state_d = S_RD_ISSUE;
            end
            if (op_i == OP_POP) sp_d = eff_addr;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (push_q) sp_d = sp_q - 8'd1;
        state_d = S_DONE;
      end
      S_RD_ISSUE: state_d = S_RD_CAPT;
      S_RD_CAPT: begin
        rdata_d = mem_do_i;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sp_q    <= SP_INIT;
      rdata_q <= 8'd0;
      addr_q  <= 8'd0;
      di_q    <= 8'd0;
      err_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      err_q   <= err_d;
      push_q  <= push_d;
    end
  end

  // Strobes are masked by reset so an aborted write never reaches memory.
  assign mem_we_o   = (state_q == S_WRITE) && !rst_i;
  assign mem_e_o    = ((state_q == S_RD_ISSUE) || (state_q == S_RD_CAPT)) && !rst_i;
  assign busy_o     = (state_q == S_WRITE) || (state_q == S_RD_ISSUE) || (state_q == S_RD_CAPT);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = (state_q == S_DONE) && err_q;
  assign rdata_o    = rdata_q;
  assign sp_o       = sp_q;
  assign mem_addr_o = addr_q;
  assign mem_di_o   = di_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_stack_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_stack_seq
// Brief   : Directed plus randomized bench for lsu_stack_seq against a transaction-level model.
// Rev     : 1.0
// ============================================================================
module tb_lsu_stack_seq;

  localparam logic [7:0] SP_INIT = 8'd32;
  localparam logic [7:0] MEM_TOP = 8'd32;

  logic       clk = 1'b0;
  logic       rst_i, req_i;
  logic [1:0] op_i;
  logic [7:0] addr_i, wdata_i;
  logic       busy_o, done_o, err_o, mem_e_o, mem_we_o;
  logic [7:0] rdata_o, sp_o, mem_addr_o, mem_di_o, mem_do_i;

  lsu_stack_seq #(.SP_INIT(SP_INIT), .MEM_TOP(MEM_TOP)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .sp_o(sp_o), .err_o(err_o), .mem_e_o(mem_e_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_di_o(mem_di_o), .mem_do_i(mem_do_i)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory; unwritten locations read as addr^0x5A.
  logic [7:0] mem   [256];
  bit         valid [256];
  int         wr_cnt = 0;
  logic [7:0] last_wa = 8'd0, last_wd = 8'd0;
  always @(posedge clk) begin
    if (mem_we_o) begin
      mem[mem_addr_o]   <= mem_di_o;
      valid[mem_addr_o] <= 1'b1;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr_o;
      last_wd <= mem_di_o;
    end
    if (mem_e_o) mem_do_i <= valid[mem_addr_o] ? mem[mem_addr_o] : (mem_addr_o ^ 8'h5A);
  end

  // Reference model state
  logic [7:0] ref_mem   [256];
  bit         ref_valid [256];
  logic [7:0] sp_m, rdata_m;
  int         npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one operation at a negedge where the DUT can accept; returns at the
  // negedge that shows done_o, with req_i already dropped.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        input bit noisy);
    logic [7:0] ea;
    bit         wr, flt;
    int         lat, cyc, wc0;
    ea  = (op == 2'b10) ? sp_m : (op == 2'b11) ? sp_m + 8'd1 : a;
    wr  = (op == 2'b01) || (op == 2'b10);
    flt = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
    flt = (ea > MEM_TOP);
`endif
    lat = flt ? 1 : (wr ? 2 : 3);
    wc0 = wr_cnt;
    req_i = 1'b1; op_i = op; addr_i = a; wdata_i = d;
    @(negedge clk);
    cyc = 1;
    chk("busy_after_accept", busy_o, !flt);
    chk("we_after_accept", mem_we_o, wr && !flt);
    while (!done_o && cyc < 8) begin
      if (mem_we_o || mem_e_o) chk("mem_addr", mem_addr_o, ea);
      req_i = noisy;
      if (noisy) begin op_i = 2'b01; addr_i = 8'($urandom); wdata_i = 8'($urandom); end
      @(negedge clk);
      cyc++;
    end
    req_i = 1'b0;
    if (!flt) begin
      if (wr) begin
        ref_mem[ea] = d; ref_valid[ea] = 1'b1;
        if (op == 2'b10) sp_m = sp_m - 8'd1;
      end else begin
        rdata_m = ref_valid[ea] ? ref_mem[ea] : (ea ^ 8'h5A);
        if (op == 2'b11) sp_m = ea;
      end
    end
    chk("latency", cyc, lat);
    chk("done", done_o, 1'b1);
    chk("err", err_o, flt);
    chk("sp", sp_o, sp_m);
    chk("rdata", rdata_o, rdata_m);
    chk("write_count", wr_cnt - wc0, (wr && !flt) ? 1 : 0);
    if (wr && !flt) begin
      chk("write_addr", last_wa, ea);
      chk("write_data", last_wd, d);
    end
  endtask

  initial begin
    int wc;
    rst_i = 1'b1; req_i = 1'b0; op_i = 2'b00; addr_i = 8'd0; wdata_i = 8'd0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    sp_m = SP_INIT; rdata_m = 8'd0;
    chk("rst_sp", sp_o, SP_INIT);
    chk("rst_rdata", rdata_o, 8'd0);
    chk("rst_addr", mem_addr_o, 8'd0);
    chk("rst_di", mem_di_o, 8'd0);
    chk("rst_strobes", {mem_e_o, mem_we_o, busy_o, done_o, err_o}, 5'd0);
    @(negedge clk);

    // ST then LD to the same address
    run_op(2'b01, 8'd5, 8'hA5, 1'b0);
    run_op(2'b00, 8'd5, 8'h00, 1'b0);
    chk("ld_a5", rdata_o, 8'hA5);
    @(negedge clk);

    // Stack round trip
    run_op(2'b10, 8'd0, 8'h11, 1'b0);
    run_op(2'b10, 8'd0, 8'h22, 1'b0);
    chk("sp_after_push", sp_o, 8'd30);
    run_op(2'b11, 8'd0, 8'd0, 1'b0);
    chk("pop1", rdata_o, 8'h22);
    run_op(2'b11, 8'd0, 8'd0, 1'b0);
    chk("pop2", rdata_o, 8'h11);
    chk("sp_restored", sp_o, 8'd32);
    @(negedge clk);

    // Requests while busy are dropped; a single done pulse follows
    run_op(2'b00, 8'd7, 8'd0, 1'b1);
    @(negedge clk);
    chk("single_done", {done_o, busy_o}, 2'b00);

    // Back-to-back: ST accepted in the DONE cycle of an LD
    run_op(2'b00, 8'd5, 8'd0, 1'b0);
    run_op(2'b01, 8'd9, 8'h3C, 1'b0);
    @(negedge clk);

    // Reset during the WRITE cycle of a PUSH
    wc = wr_cnt;
    req_i = 1'b1; op_i = 2'b10; wdata_i = 8'h77;
    @(negedge clk);
    req_i = 1'b0;
    chk("push_in_write", mem_we_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    sp_m = SP_INIT; rdata_m = 8'd0;
    chk("abort_no_write", wr_cnt - wc, 0);
    chk("abort_sp", sp_o, SP_INIT);
    chk("abort_rdata", rdata_o, 8'd0);
    repeat (3) begin
      chk("abort_no_done", {done_o, busy_o}, 2'b00);
      @(negedge clk);
    end

`ifdef LSU_BOUNDS_CHECK_EN
    // Out-of-range load faults immediately
    wc = wr_cnt;
    run_op(2'b00, 8'd40, 8'd0, 1'b0);
    chk("oob_no_access", wr_cnt - wc, 0);
    @(negedge clk);
`endif

    // Randomized traffic with random idle gaps and dropped-request noise
    for (int i = 0; i < 150; i++) begin
      run_op(2'($urandom), 8'($urandom_range(0, 63)), 8'($urandom), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
